// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of shadow control words; a CTRL commit copies dirty shadows to the active outputs in one cycle.
// Ack one cycle after select; a held select gets a single ack and waits for release (no retry/timeout path).
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01100500,
    parameter logic [31:0] C_HIGHADDR    = 32'h011005FF,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_REG_WIDTH   = 32,
    parameter logic [31:0] C_RESET_VAL   = 32'h0,
    parameter int          C_AUTO_COMMIT = 0
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    input  logic [0:31]                       OPB_ABus,
    input  logic [0:3]                        OPB_BE,
    input  logic [0:31]                       OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:31]                       Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_update
);
    localparam int N = C_NUM_REGS;
    localparam int W = C_REG_WIDTH;
    localparam logic [W-1:0] RST_VAL = C_RESET_VAL[W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;
    state_t state, state_nxt;

    // Assigning the big-endian bus to [31:0] makes bit j of the word equal DBus[31-j].
    logic [31:0] addr, wdat, offset, rd_word, rd_q;
    logic [3:0]  be;
    logic [29:0] word;
    logic        in_win, ctrl_hit, stat_hit, do_write, do_commit;

    assign addr     = OPB_ABus;
    assign wdat     = OPB_DBus;
    assign be       = OPB_BE;
    assign offset   = addr - C_BASEADDR;
    assign word     = offset[31:2];
    assign in_win   = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign ctrl_hit = in_win && (word == 30'd30);
    assign stat_hit = in_win && (word == 30'd31);
    assign do_write  = (state == S_ACK) && !OPB_RNW && in_win;
    assign do_commit = do_write && ctrl_hit && wdat[0];

    logic [W-1:0]  shadow [N];
    logic [W-1:0]  active [N];
    logic [N-1:0]  dirty, wr_sel;
    logic [15:0]   commit_cnt;
    logic [W-1:0]  shadow_cur, wr_val;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

    function automatic logic [W-1:0] merge_bytes(input logic [W-1:0] old);
        logic [31:0] t;
        t = 32'(old);
        for (int b = 0; b < 4; b++)
            if (be[b]) t[8*b +: 8] = wdat[8*b +: 8];
        return t[W-1:0];
    endfunction

    always_comb begin
        rd_word    = '0;
        shadow_cur = '0;
        wr_sel     = '0;
        if (stat_hit) begin
            rd_word[31:16]  = commit_cnt;
            rd_word[N-1:0]  = dirty;
        end
        for (int k = 0; k < N; k++) begin
            if (in_win && word == 30'(k)) begin
                rd_word[W-1:0] = shadow[k];
                shadow_cur     = shadow[k];
                wr_sel[k]      = do_write;
            end
        end
        wr_val = merge_bytes(shadow_cur);
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (OPB_select && in_win) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_WAIT;
            S_WAIT:  if (!OPB_select) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data is captured on entry to ACK and is zero on every other cycle.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst)                                         rd_q <= '0;
        else if (state == S_IDLE && state_nxt == S_ACK && OPB_RNW) rd_q <= rd_word;
        else                                                 rd_q <= '0;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int k = 0; k < N; k++) begin
                shadow[k] <= RST_VAL;
                active[k] <= RST_VAL;
            end
            dirty       <= '0;
            commit_cnt  <= '0;
            user_update <= '0;
        end else begin
            user_update <= '0;
            if (do_commit) begin
                for (int k = 0; k < N; k++)
                    if (dirty[k]) active[k] <= shadow[k];
                user_update <= dirty;
                dirty       <= '0;
                commit_cnt  <= commit_cnt + 16'd1;
            end
            for (int k = 0; k < N; k++) begin
                if (wr_sel[k]) begin
                    shadow[k] <= wr_val;
                    if (C_AUTO_COMMIT != 0) begin
                        active[k]      <= wr_val;
                        user_update[k] <= 1'b1;
                    end else begin
                        dirty[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign user_data_out[i*W +: W] = active[i];
    end

    assign Sl_DBus    = rd_q;
    assign Sl_xferAck = (state == S_ACK);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench: manual-commit bank plus an auto-commit bank sharing the same OPB bus.
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE = 32'h01100500;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] abus, dbus;
    logic [3:0]  be;
    logic        rnw, sel, seq;
    logic [31:0] sl_dbus;
    logic        ack, err, retry, tout;
    logic [255:0] udo;
    logic [7:0]  upd;
    logic [31:0] unused_a_dbus;
    logic        unused_a_ack, unused_a_err, unused_a_retry, unused_a_tout;
    logic [255:0] a_udo;
    logic [7:0]  a_upd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(32'h011005FF), .C_NUM_REGS(8),
        .C_REG_WIDTH(32), .C_RESET_VAL(32'h0), .C_AUTO_COMMIT(0)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_out(udo), .user_update(upd)
    );

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(32'h011005FF), .C_NUM_REGS(8),
        .C_REG_WIDTH(32), .C_RESET_VAL(32'h0), .C_AUTO_COMMIT(1)
    ) u_auto (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(unused_a_dbus), .Sl_xferAck(unused_a_ack), .Sl_errAck(unused_a_err),
        .Sl_retry(unused_a_retry), .Sl_toutSup(unused_a_tout),
        .user_data_out(a_udo), .user_update(a_upd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] off, input logic r, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd);
        int lat;
        lat = -1;
        rd  = '0;
        @(posedge clk); #1;
        abus = BASE + off; rnw = r; dbus = d; be = b; sel = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c;
                rd  = sl_dbus;
                break;
            end
        end
        chk("ack_latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b1; dbus = '0; be = '0;
    endtask

    typedef struct {
        logic [31:0] off;
        logic        r;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] rd;
        int acks;

        tbl[0] = '{32'h0C, 1'b1, 32'h0,        4'h0,    32'h0};
        tbl[1] = '{32'h08, 1'b0, 32'hDEADBEEF, 4'b0110, 32'h0};
        tbl[2] = '{32'h08, 1'b1, 32'h0,        4'h0,    32'h00ADBE00};
        tbl[3] = '{32'h7C, 1'b1, 32'h0,        4'h0,    32'h00000004};
        tbl[4] = '{32'h40, 1'b1, 32'h0,        4'h0,    32'h0};
        tbl[5] = '{32'h40, 1'b0, 32'hFFFFFFFF, 4'hF,    32'h0};
        tbl[6] = '{32'h78, 1'b1, 32'h0,        4'h0,    32'h0};
        tbl[7] = '{32'h1C, 1'b0, 32'h12345678, 4'b1001, 32'h0};
        tbl[8] = '{32'h1C, 1'b1, 32'h0,        4'h0,    32'h12000078};
        tbl[9] = '{32'h7C, 1'b1, 32'h0,        4'h0,    32'h00000084};

        rst = 1'b1; abus = '0; dbus = '0; be = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ack", {31'b0, ack}, 32'd0);
        chk("reset_dbus", sl_dbus, 32'd0);
        chk("reset_upd", 32'(upd), 32'd0);
        chk("tied_outputs", {29'b0, err, retry, tout}, 32'd0);
        for (int k = 0; k < 8; k++) chk("reset_active", udo[k*32 +: 32], 32'd0);

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].off, tbl[i].r, tbl[i].d, tbl[i].b, rd);
            if (tbl[i].r) chk($sformatf("vec%0d_read", i), rd, tbl[i].exp);
        end
        @(negedge clk);
        for (int k = 0; k < 8; k++) chk("active_before_commit", udo[k*32 +: 32], 32'd0);
        chk("no_update_on_write", 32'(upd), 32'd0);

        xfer(32'h78, 1'b0, 32'h00000001, 4'hF, rd);
        @(negedge clk);
        chk("commit1_upd", 32'(upd), 32'h84);
        chk("commit1_reg2", udo[95:64], 32'h00ADBE00);
        chk("commit1_reg7", udo[255:224], 32'h12000078);
        @(negedge clk);
        chk("commit1_upd_drop", 32'(upd), 32'd0);
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("status_after_commit1", rd, 32'h00010000);

        xfer(32'h00, 1'b0, 32'h11223344, 4'hF, rd);
        @(negedge clk);
        chk("auto_upd_reg0", 32'(a_upd), 32'h01);
        chk("auto_active_reg0", a_udo[31:0], 32'h11223344);
        chk("manual_no_upd", 32'(upd), 32'd0);
        @(negedge clk);
        chk("auto_upd_drop", 32'(a_upd), 32'd0);
        xfer(32'h14, 1'b0, 32'hA5A55A5A, 4'hF, rd);
        xfer(32'h78, 1'b0, 32'h80000001, 4'hF, rd);
        @(negedge clk);
        chk("commit2_upd", 32'(upd), 32'h21);
        chk("commit2_reg0", udo[31:0], 32'h11223344);
        chk("commit2_reg5", udo[191:160], 32'hA5A55A5A);
        chk("commit2_reg2_kept", udo[95:64], 32'h00ADBE00);
        @(negedge clk);
        chk("commit2_upd_drop", 32'(upd), 32'd0);
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("status_after_commit2", rd, 32'h00020000);

        xfer(32'h78, 1'b0, 32'hFFFFFFFE, 4'hF, rd);
        @(negedge clk);
        chk("ctrl_bit_clear_upd", 32'(upd), 32'd0);
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("ctrl_bit_clear_status", rd, 32'h00020000);

        @(posedge clk); #1;
        abus = BASE + 32'h0C; rnw = 1'b1; sel = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("held_select_acks", 32'(acks), 32'd1);
        @(posedge clk); #1 sel = 1'b0;
        repeat (2) @(posedge clk);

        @(negedge clk);
        force dut.commit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.commit_cnt;
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("status_preload", rd, 32'hFFFF0000);
        xfer(32'h78, 1'b0, 32'h00000001, 4'hF, rd);
        @(negedge clk);
        chk("empty_commit_upd", 32'(upd), 32'd0);
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("counter_wrap", rd, 32'h00000000);

        @(posedge clk); #1;
        abus = BASE + 32'h04; rnw = 1'b0; dbus = 32'hCAFEF00D; be = 4'hF; sel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midack_ack_seen", {31'b0, ack}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midack_ack_drop", {31'b0, ack}, 32'd0);
        chk("midack_dbus", sl_dbus, 32'd0);
        chk("midack_upd", 32'(upd), 32'd0);
        for (int k = 0; k < 8; k++) chk("midack_active", udo[k*32 +: 32], 32'd0);
        sel = 1'b0; rnw = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        xfer(32'h04, 1'b1, 32'h0, 4'h0, rd);
        chk("midack_reg1_not_written", rd, 32'd0);
        xfer(32'h00, 1'b1, 32'h0, 4'h0, rd);
        chk("midack_reg0_reset", rd, 32'd0);
        xfer(32'h7C, 1'b1, 32'h0, 4'h0, rd);
        chk("midack_status_reset", rd, 32'd0);

        xfer(32'h0C, 1'b0, 32'h0BADF00D, 4'hF, rd);
        @(negedge clk);
        chk("auto_upd_reg3", 32'(a_upd), 32'h08);
        chk("auto_active_reg3", a_udo[127:96], 32'h0BADF00D);
        chk("manual_reg3_inactive", udo[127:96], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
